// File: rtl/xillybus_loop_regs.sv
// Xillybus user-side block: write_32 -> read_32 loopback FIFO plus a 32-word
// mem_32 register window (control, status, counters, ID, scratch RAM).
module xillybus_loop_regs #(
  parameter int unsigned FIFO_AW  = 9,
  parameter logic [31:0] ID_VALUE = 32'h584C_0001
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        user_w_write_32_wren,
  input  logic [31:0] user_w_write_32_data,
  output logic        user_w_write_32_full,
  input  logic        user_w_write_32_open,
  input  logic        user_r_read_32_rden,
  output logic [31:0] user_r_read_32_data,
  output logic        user_r_read_32_empty,
  output logic        user_r_read_32_eof,
  input  logic        user_r_read_32_open,
  input  logic        user_w_mem_32_wren,
  input  logic [31:0] user_w_mem_32_data,
  output logic        user_w_mem_32_full,
  input  logic        user_r_mem_32_rden,
  output logic [31:0] user_r_mem_32_data,
  output logic        user_r_mem_32_empty,
  output logic        user_r_mem_32_eof,
  input  logic [4:0]  user_mem_32_addr
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FILL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   FILL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};

  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   fill_q, fill_d;
  logic               empty_q, empty_d, full_q, full_d, eof_q, eof_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               eof_arm_q, eof_arm_d, loop_en_q, loop_en_d;
  logic [31:0]        words_in_q, words_in_d, words_out_q, words_out_d;
  logic [31:0]        drop_q, drop_d, high_q, high_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic [31:0]        scratch_q [8:31];
  logic [31:0]        scratch_d [8:31];

  logic        ctrl_wr, flush, rd_acc, wr_acc;
  logic [31:0] status_word, win_word, fill_ext;

  assign ctrl_wr = user_w_mem_32_wren && (user_mem_32_addr == 5'd0);
  assign flush   = (ctrl_wr && user_w_mem_32_data[0]) ||
                   (!user_w_write_32_open && !user_r_read_32_open);
  assign rd_acc  = user_r_read_32_rden && !empty_q && !flush;
  // A read in the same cycle frees a slot, so a full FIFO still takes the write.
  assign wr_acc  = user_w_write_32_wren && loop_en_q && !flush &&
                   ((fill_q != FILL_FULL) || rd_acc);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = fifo_mem[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   fill_d = fill_q + FILL_ONE;
        2'b01:   fill_d = fill_q - FILL_ONE;
        default: fill_d = fill_q;
      endcase
    end
  end

  always_comb begin
    eof_arm_d = eof_arm_q;
    loop_en_d = loop_en_q;
    // A flush command only flushes; the other control bits keep their values.
    if (ctrl_wr && !user_w_mem_32_data[0]) begin
      eof_arm_d = user_w_mem_32_data[1];
      loop_en_d = user_w_mem_32_data[2];
    end
    empty_d = (fill_d == '0);
    full_d  = (fill_d == FILL_FULL) && loop_en_d;
    eof_d   = eof_arm_d && empty_d;
  end

  assign fill_ext = {{(31 - FIFO_AW){1'b0}}, fill_d};

  always_comb begin
    words_in_d  = words_in_q + {31'b0, wr_acc};
    words_out_d = words_out_q + {31'b0, rd_acc};
    drop_d      = drop_q + {31'b0, user_w_write_32_wren && !wr_acc};
    high_d      = (fill_ext > high_q) ? fill_ext : high_q;
    if (user_w_mem_32_wren) begin
      case (user_mem_32_addr)
        5'd2:    words_in_d  = '0;
        5'd3:    words_out_d = '0;
        5'd4:    drop_d      = '0;
        5'd5:    high_d      = {{(31 - FIFO_AW){1'b0}}, fill_q};
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 8; i < 32; i++) begin
      scratch_d[i] = scratch_q[i];
      if (user_w_mem_32_wren && (user_mem_32_addr == 5'(i)))
        scratch_d[i] = user_w_mem_32_data;
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[FIFO_AW:0]     = fill_q;
    status_word[16]            = empty_q;
    status_word[17]            = full_q;
    status_word[18]            = user_w_write_32_open;
    status_word[19]            = user_r_read_32_open;
  end

  // Window reads see the register values from before this edge's writes.
  always_comb begin
    case (user_mem_32_addr)
      5'd0:    win_word = {29'b0, loop_en_q, eof_arm_q, 1'b0};
      5'd1:    win_word = status_word;
      5'd2:    win_word = words_in_q;
      5'd3:    win_word = words_out_q;
      5'd4:    win_word = drop_q;
      5'd5:    win_word = high_q;
      5'd6:    win_word = ID_VALUE;
      5'd7:    win_word = '0;
      default: win_word = scratch_q[user_mem_32_addr];
    endcase
    mem_data_d = user_r_mem_32_rden ? win_word : mem_data_q;
  end

  always_ff @(posedge bus_clk) begin
    if (wr_acc) fifo_mem[wr_ptr_q] <= user_w_write_32_data;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      eof_q       <= 1'b0;
      rd_data_q   <= '0;
      eof_arm_q   <= 1'b0;
      loop_en_q   <= 1'b1;
      words_in_q  <= '0;
      words_out_q <= '0;
      drop_q      <= '0;
      high_q      <= '0;
      mem_data_q  <= '0;
      for (int unsigned i = 8; i < 32; i++) scratch_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      eof_q       <= eof_d;
      rd_data_q   <= rd_data_d;
      eof_arm_q   <= eof_arm_d;
      loop_en_q   <= loop_en_d;
      words_in_q  <= words_in_d;
      words_out_q <= words_out_d;
      drop_q      <= drop_d;
      high_q      <= high_d;
      mem_data_q  <= mem_data_d;
      scratch_q   <= scratch_d;
    end
  end

  assign user_w_write_32_full = full_q;
  assign user_r_read_32_data  = rd_data_q;
  assign user_r_read_32_empty = empty_q;
  assign user_r_read_32_eof   = eof_q;
  assign user_r_mem_32_data   = mem_data_q;
  assign user_w_mem_32_full   = 1'b0;
  assign user_r_mem_32_empty  = 1'b0;
  assign user_r_mem_32_eof    = 1'b0;

endmodule

// File: tb/tb_xillybus_loop_regs.sv
// Bench for xillybus_loop_regs: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based model of the block.
module tb_xillybus_loop_regs;

  localparam int unsigned FIFO_AW = 9;
  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam logic [31:0] ID_VAL  = 32'h584C_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_wren, w_open, r_rden, r_open, mw_en, mr_en;
  logic [31:0] w_data, mw_data;
  logic [4:0]  m_addr;
  logic        w_full, r_empty, r_eof, mw_full, mr_empty, mr_eof;
  logic [31:0] r_data, mr_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] e_rdata, e_mem, e_in, e_out, e_drop, e_hw;
  logic        e_empty, e_full, e_eof, e_arm, e_loop;
  logic [31:0] e_scr [32];

  always #5 clk = ~clk;

  xillybus_loop_regs #(.FIFO_AW(FIFO_AW), .ID_VALUE(ID_VAL)) dut (
    .bus_clk(clk), .bus_rst(rst),
    .user_w_write_32_wren(w_wren), .user_w_write_32_data(w_data),
    .user_w_write_32_full(w_full), .user_w_write_32_open(w_open),
    .user_r_read_32_rden(r_rden), .user_r_read_32_data(r_data),
    .user_r_read_32_empty(r_empty), .user_r_read_32_eof(r_eof),
    .user_r_read_32_open(r_open),
    .user_w_mem_32_wren(mw_en), .user_w_mem_32_data(mw_data),
    .user_w_mem_32_full(mw_full), .user_r_mem_32_rden(mr_en),
    .user_r_mem_32_data(mr_data), .user_r_mem_32_empty(mr_empty),
    .user_r_mem_32_eof(mr_eof), .user_mem_32_addr(m_addr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] win_word(input logic [4:0] a, input int unsigned f);
    logic [31:0] s = '0;
    case (a)
      5'd0: s = {29'b0, e_loop, e_arm, 1'b0};
      5'd1: begin
        s[FIFO_AW:0] = f[FIFO_AW:0];
        s[16] = (f == 0); s[17] = e_full; s[18] = w_open; s[19] = r_open;
      end
      5'd2: s = e_in;
      5'd3: s = e_out;
      5'd4: s = e_drop;
      5'd5: s = e_hw;
      5'd6: s = ID_VAL;
      5'd7: s = '0;
      default: s = e_scr[a];
    endcase
    return s;
  endfunction

  task automatic model_step();
    int unsigned f;
    bit flush, rd_ok, wr_ok;
    if (rst) begin
      mq.delete();
      e_rdata = '0; e_mem = '0; e_in = '0; e_out = '0; e_drop = '0; e_hw = '0;
      e_empty = 1'b1; e_full = 1'b0; e_eof = 1'b0; e_arm = 1'b0; e_loop = 1'b1;
      for (int i = 0; i < 32; i++) e_scr[i] = '0;
      return;
    end
    f     = mq.size();
    flush = (mw_en && m_addr == 0 && mw_data[0]) || (!w_open && !r_open);
    rd_ok = r_rden && f != 0 && !flush;
    wr_ok = w_wren && e_loop && !flush && (f < DEPTH || rd_ok);
    if (mr_en) e_mem = win_word(m_addr, f);
    if (flush) mq.delete();
    else begin
      if (rd_ok) e_rdata = mq.pop_front();
      if (wr_ok) mq.push_back(w_data);
    end
    e_in   = (mw_en && m_addr == 2) ? 0 : e_in + (wr_ok ? 1 : 0);
    e_out  = (mw_en && m_addr == 3) ? 0 : e_out + (rd_ok ? 1 : 0);
    e_drop = (mw_en && m_addr == 4) ? 0 : e_drop + ((w_wren && !wr_ok) ? 1 : 0);
    if (mw_en && m_addr == 5) e_hw = f;
    else if (mq.size() > e_hw) e_hw = mq.size();
    if (mw_en && m_addr == 0 && !mw_data[0]) begin
      e_arm = mw_data[1]; e_loop = mw_data[2];
    end
    if (mw_en && m_addr >= 8) e_scr[m_addr] = mw_data;
    e_empty = (mq.size() == 0);
    e_full  = (mq.size() == DEPTH) && e_loop;
    e_eof   = e_arm && e_empty;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    check_eq("rd_data", r_data, e_rdata);
    check_eq("empty", {31'b0, r_empty}, {31'b0, e_empty});
    check_eq("full", {31'b0, w_full}, {31'b0, e_full});
    check_eq("eof", {31'b0, r_eof}, {31'b0, e_eof});
    check_eq("mem_data", mr_data, e_mem);
  endtask

  task automatic mem_write(input logic [4:0] a, input logic [31:0] d);
    mw_en = 1'b1; m_addr = a; mw_data = d;
    tick();
    mw_en = 1'b0;
  endtask

  task automatic mem_read(input logic [4:0] a);
    mr_en = 1'b1; m_addr = a;
    tick();
    mr_en = 1'b0;
  endtask

  task automatic push_words(input int unsigned n);
    w_wren = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      w_data = $urandom;
      tick();
    end
    w_wren = 1'b0;
  endtask

  initial begin
    logic [31:0] drop0;
    rst = 1'b1; w_wren = 0; r_rden = 0; mw_en = 0; mr_en = 0;
    w_open = 0; r_open = 0; w_data = '0; mw_data = '0; m_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_empty", {31'b0, r_empty}, 32'd1);
    check_eq("rst_full", {31'b0, w_full}, 32'd0);
    check_eq("rst_eof", {31'b0, r_eof}, 32'd0);
    check_eq("tied_zero", {29'b0, mw_full, mr_empty, mr_eof}, 32'd0);
    mem_read(5'd0); check_eq("ctrl_rst", mr_data, 32'h4);
    mem_read(5'd6); check_eq("id", mr_data, 32'h584C0001);

    // Ordered loopback
    w_open = 1; r_open = 1; tick();
    w_wren = 1;
    for (int unsigned i = 1; i <= 3; i++) begin w_data = i; tick(); end
    w_wren = 0; r_rden = 1;
    for (int unsigned i = 1; i <= 3; i++) begin tick(); check_eq("rd_seq", r_data, i); end
    r_rden = 0;
    mem_read(5'd2); check_eq("words_in", mr_data, 32'd3);
    mem_read(5'd3); check_eq("words_out", mr_data, 32'd3);
    mem_read(5'd5); check_eq("high_water", mr_data, 32'd3);
    check_eq("empty_after", {31'b0, r_empty}, 32'd1);

    // Fill to depth, overflow drop, read+write while full
    push_words(DEPTH);
    check_eq("full_at_depth", {31'b0, w_full}, 32'd1);
    push_words(1);
    mem_read(5'd4); check_eq("drop_one", mr_data, 32'd1);
    w_wren = 1; r_rden = 1; w_data = 32'hCAFE_F00D; tick(); w_wren = 0; r_rden = 0;
    mem_read(5'd1); check_eq("fill_full_rw", mr_data & 32'h3FF, DEPTH);
    r_rden = 1; repeat (DEPTH) tick(); r_rden = 0;
    check_eq("drain_empty", {31'b0, r_empty}, 32'd1);
    check_eq("drain_last", r_data, 32'hCAFE_F00D);

    // EOF arming and flush command
    mem_write(5'd0, 32'h6);
    push_words(4);
    r_rden = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check_eq("eof_drain", {31'b0, r_eof}, (i == 3) ? 32'd1 : 32'd0);
    end
    r_rden = 0;
    mem_write(5'd0, 32'h4);
    push_words(3);
    mem_write(5'd0, 32'h1);
    check_eq("flush_empty", {31'b0, r_empty}, 32'd1);
    mem_read(5'd0); check_eq("ctrl_after_flush", mr_data, 32'h4);

    // Close-driven flush, disabled loop, clear-vs-increment
    push_words(10);
    w_open = 0; r_open = 0; tick();
    check_eq("close_flush", {31'b0, r_empty}, 32'd1);
    w_open = 1; r_open = 1;
    mem_read(5'd1); check_eq("close_fill", mr_data & 32'h3FF, 32'd0);
    mem_write(5'd0, 32'h0);
    drop0 = e_drop;
    push_words(1);
    check_eq("noloop_full", {31'b0, w_full}, 32'd0);
    mem_read(5'd4); check_eq("noloop_drop", mr_data, drop0 + 1);
    w_wren = 1; mw_en = 1; m_addr = 5'd4; mw_data = 32'h1234; tick();
    w_wren = 0; mw_en = 0;
    mem_read(5'd4); check_eq("drop_clear_wins", mr_data, 32'd0);
    mem_write(5'd0, 32'h4);

    // Scratch RAM
    mem_write(5'd31, 32'hDEADBEEF);
    mem_read(5'd31); check_eq("scratch31", mr_data, 32'hDEADBEEF);
    mem_write(5'd8, 32'h1111_1111);
    mw_en = 1; mr_en = 1; m_addr = 5'd8; mw_data = 32'h2222_2222; tick();
    mw_en = 0; mr_en = 0;
    check_eq("rw_same_old", mr_data, 32'h1111_1111);
    mem_read(5'd8); check_eq("rw_same_new", mr_data, 32'h2222_2222);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      w_wren = ($urandom_range(3) != 0);
      w_data = $urandom;
      r_rden = ($urandom_range(2) == 0);
      w_open = ($urandom_range(15) != 0);
      r_open = ($urandom_range(15) != 0);
      mw_en  = ($urandom_range(7) == 0);
      mr_en  = ($urandom_range(3) == 0);
      m_addr = 5'($urandom_range(31));
      mw_data = $urandom;
      if (m_addr == 0) begin
        mw_data[0] = ($urandom_range(15) == 0);
        mw_data[2] = ($urandom_range(7) != 0);
      end
      tick();
    end
    w_wren = 0; r_rden = 0; mw_en = 0; mr_en = 0; w_open = 1; r_open = 1;

    // Reset mid-transfer
    mem_write(5'd0, 32'h4);
    push_words(5);
    rst = 1; tick(); rst = 0; tick();
    check_eq("rst2_empty", {31'b0, r_empty}, 32'd1);
    mem_read(5'd31); check_eq("rst2_scratch", mr_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
